// File: rtl/piso_tx_if.sv
// piso_tx_if -- word-in / bit-out handshake bundle for the piso_tx serializer.
//   i_valid  source offers i_data
//   i_data   parallel word, WIDTH bits
//   o_ready  serializer accepts a word this cycle
//   o_sd     serial data bit
//   o_frame  o_sd carries a frame bit
//   o_done   one-cycle pulse after the last frame bit
// master: the word source / bit sink.  slave: the serializer.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_sd;
  logic             o_frame;
  logic             o_done;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_sd, o_frame, o_done
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_sd, o_frame, o_done
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake, then shifts it out one
// bit per clock (MSB or LSB first), optionally followed by an even-parity bit,
// and finishes each frame with a one-cycle done pulse.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    piso_tx_if slave modport (i_valid, i_data, o_ready, o_sd, o_frame, o_done)
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  piso_tx_if.slave  bus
);

  // Counter holds at most WIDTH+1, so WIDTH+2 codes are enough and it never wraps.
  localparam int              CW      = $clog2(WIDTH + 2);
  localparam int              N_BITS  = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam logic [CW-1:0]   CNT_LD  = CW'(N_BITS);
  localparam logic [CW-1:0]   CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0]   CNT_TWO = CW'(32'd2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             par_r;
  logic             sd_r;
  logic             frame_r;
  logic             done_r;

  // XOR of the payload: appending it makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Bit that leaves first from a word in the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] d);
    return (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
  endfunction

  // Word with its head bit removed, zero-filled at the far end.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] d);
    return (MSB_FIRST != 0) ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
  endfunction

  // Frame FSM with shift register, bit counter and registered serial outputs.
  // o_sd is registered, so the head bit is loaded straight from i_data at the
  // accepting edge and the shift register keeps only the bits still to come.
  // cnt_r counts the frame bits not yet retired; the bit being shown when it
  // is 1 is the last one, and with parity enabled cnt_r==2 selects parity next.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      par_r   <= 1'b0;
      sd_r    <= 1'b0;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.i_valid) begin
            state_r <= SHIFT;
            shreg_r <= drop_head(bus.i_data);
            par_r   <= even_parity(bus.i_data);
            cnt_r   <= CNT_LD;
            sd_r    <= head_bit(bus.i_data);
            frame_r <= 1'b1;
          end else begin
            sd_r    <= 1'b0;
            frame_r <= 1'b0;
          end
        end
        SHIFT: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= DONE;
            sd_r    <= 1'b0;
            frame_r <= 1'b0;
            done_r  <= 1'b1;
          end else if ((PARITY_EN != 0) && (cnt_r == CNT_TWO)) begin
            sd_r    <= par_r;
          end else begin
            sd_r    <= head_bit(shreg_r);
            shreg_r <= drop_head(shreg_r);
          end
        end
        DONE: begin
          state_r <= IDLE;
          sd_r    <= 1'b0;
          frame_r <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          sd_r    <= 1'b0;
          frame_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = (state_r == IDLE);
  assign bus.o_sd    = sd_r;
  assign bus.o_frame = frame_r;
  assign bus.o_done  = done_r;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per frame, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 Parameter PARITY_EN, default 0: 1 appends one even-parity bit after the payload.
REQ-004 i_clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  the word on i_data is offered for transmission.
REQ-007 i_data  input  WIDTH  parallel word to serialize.
REQ-008 o_ready  output  1  block accepts a word this cycle.
REQ-009 o_sd  output  1  serial data bit, registered.
REQ-010 o_frame  output  1  o_sd carries a valid frame bit this cycle, registered.
REQ-011 o_done  output  1  one-cycle pulse after the last frame bit, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 o_ready SHALL equal 1 in IDLE and 0 in SHIFT and DONE, decoded from state only.
REQ-014 Handshake: a word SHALL be accepted at a rising edge where i_valid=1 and o_ready=1; i_data is captured into the shift register at that edge.
REQ-015 After acceptance the block SHALL move IDLE->SHIFT and load the bit counter with N = WIDTH + PARITY_EN.
REQ-016 In the N cycles after the accepting edge, o_frame SHALL be 1 and o_sd SHALL present one frame bit per cycle in the configured order, with the parity bit last when enabled.
REQ-017 Parity bit SHALL be the XOR of all WIDTH captured bits, giving even parity over payload plus parity.
REQ-018 After the final bit cycle the block SHALL enter DONE for exactly one cycle with o_done=1, o_frame=0 and o_sd=0, then return to IDLE.
REQ-019 Latency: first bit at accepting edge +1 cycle; o_done at +N+1; o_ready high again at +N+2.
REQ-020 Outside SHIFT, o_frame SHALL be 0 and o_sd SHALL be 0.
REQ-021 i_valid and i_data in SHIFT or DONE SHALL be ignored, with no queueing; the source holds i_valid until it sees o_ready=1.
REQ-022 Changes on i_data after the accepting edge SHALL NOT affect the frame in flight.
REQ-023 i_valid held high continuously SHALL produce back-to-back frames separated by exactly one DONE cycle and one IDLE cycle.
REQ-024 The bit counter SHALL be sized ceil(log2(WIDTH+2)) bits and SHALL never wrap; it SHALL reach 0 exactly when SHIFT exits.

Reset
REQ-025 i_rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, the shift register to 0, the counter to 0, o_sd=0, o_frame=0 and o_done=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no o_done pulse is produced for the aborted word.
REQ-027 While i_rst=1, o_ready SHALL be 1 (IDLE), but no word SHALL be accepted.
REQ-028 The first acceptance after reset release SHALL occur at the first rising edge with i_rst=0 and i_valid=1.

Verification
REQ-029 Scenario 1: WIDTH=8, MSB_FIRST=1, PARITY_EN=0, i_data=0xC8 with one-cycle i_valid -> o_sd = 1,1,0,0,1,0,0,0 over 8 cycles with o_frame high; o_done at cycle 9; o_ready=1 at cycle 10.
REQ-030 Scenario 2: MSB_FIRST=0, i_data=0xC8 -> o_sd = 0,0,0,1,0,0,1,1.
REQ-031 Scenario 3: PARITY_EN=1, MSB_FIRST=1, i_data=0xC8 -> 9 frame bits ending in parity 1; with i_data=0xC9, parity bit 0; o_done at cycle 10.
REQ-032 Scenario 4: i_valid held high with 0xAA then 0x55 -> two frames, o_frame low for exactly 2 cycles between them; i_data changed mid-frame does not alter the bits.
REQ-033 Scenario 5: i_rst pulsed high during bit 4 of a frame, asynchronous to i_clk -> o_frame, o_sd and o_done drop to 0 before the next edge; no o_done follows; the next word is sent cleanly.
REQ-034 Scenario 6: i_valid=1 while in SHIFT or DONE -> no capture and no change in o_sd sequence; acceptance occurs only in IDLE.
